// File: rtl/product_accumulator_pkg.sv
// product_accumulator_pkg: state encoding and default widths for the product accumulator.
package product_accumulator_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF = 16;
  localparam int LEN_W_DEF = 4;
endpackage

// File: rtl/product_accumulator_add.sv
// product_accumulator_add: ACC_W-bit accumulate adder with carry out.
// PRODUCT_ACCUMULATOR_SATURATE_EN clamps to all-ones on carry; otherwise wraps.
module product_accumulator_add #(
  parameter int PROD_W = 8,
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] product,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);
  logic [ACC_W:0] full;
  assign full = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};
  assign carry = full[ACC_W];
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  assign sum = carry ? '1 : full[ACC_W-1:0];
`else
  assign sum = full[ACC_W-1:0];
`endif
endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums len products into an ACC_W result with sticky overflow.
// Overflow behaviour (wrap or clamp) selected by PRODUCT_ACCUMULATOR_SATURATE_EN.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic              busy
);
  state_t state, nxt;
  logic [ACC_W-1:0] acc, sum;
  logic [LEN_W-1:0] rem;
  logic ovf, carry, take, load;

  product_accumulator_add #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_add (
    .acc(acc),
    .product(in_product),
    .sum(sum),
    .carry(carry)
  );

  assign in_ready = state == ACCUM;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign out_sum = acc;
  assign out_ovf = ovf;
  assign take = in_valid && in_ready;
  assign load = state == IDLE && start;

  always_comb begin
    nxt = state;
    if (load) nxt = (len == '0) ? DONE : ACCUM;
    else if (take && rem == LEN_W'(1)) nxt = DONE;
    else if (out_valid && out_ready) nxt = IDLE;
  end

  // a reset mid-job drops the partial sum; the next start clears it anyway
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      ovf <= 1'b0;
      rem <= '0;
    end else begin
      state <= nxt;
      if (load) begin
        acc <= '0;
        ovf <= 1'b0;
        rem <= len;
      end else if (take) begin
        acc <= sum;
        ovf <= ovf | carry;
        rem <= rem - LEN_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: table-driven and random jobs on 16-bit and 10-bit accumulators.
module tb_product_accumulator;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] len = '0;
  logic [7:0] in_product = '0;
  logic in_ready, out_valid, out_ovf, busy;
  logic in_ready10, out_valid10, out_ovf10, busy10;
  logic [15:0] out_sum;
  logic [9:0] out_sum10;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  product_accumulator u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_ovf(out_ovf), .busy(busy)
  );

  product_accumulator #(.ACC_W(10)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready10), .in_product(in_product),
    .out_valid(out_valid10), .out_ready(out_ready), .out_sum(out_sum10),
    .out_ovf(out_ovf10), .busy(busy10)
  );

  typedef struct {
    int n;
    logic [14:0][7:0] p;
    int gap;
    int hold;
    bit ign;
    logic [15:0] s16;
    logic o16;
    logic [9:0] s10;
    logic o10;
  } vec_t;

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  localparam logic [9:0] E1X5_10 = 10'h3FF;
  localparam logic [9:0] FFX15_10 = 10'h3FF;
`else
  localparam logic [9:0] E1X5_10 = 10'h065;
  localparam logic [9:0] FFX15_10 = 10'h2F1;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: plain integer sum of the job, then wrap or clamp into each width
  task automatic model(inout vec_t v);
    int t = 0;
    for (int i = 0; i < v.n; i++) t += int'(v.p[i]);
    v.s16 = t[15:0];
    v.o16 = t > 65535;
    v.o10 = t > 1023;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    v.s10 = v.o10 ? 10'h3FF : t[9:0];
`else
    v.s10 = t[9:0];
`endif
  endtask

  task automatic check_result(input string tag, input vec_t v);
    check({tag, "_valid"}, 32'(out_valid), 32'(1));
    check({tag, "_sum"}, 32'(out_sum), 32'(v.s16));
    check({tag, "_ovf"}, 32'(out_ovf), 32'(v.o16));
    check({tag, "_valid10"}, 32'(out_valid10), 32'(1));
    check({tag, "_sum10"}, 32'(out_sum10), 32'(v.s10));
    check({tag, "_ovf10"}, 32'(out_ovf10), 32'(v.o10));
    check({tag, "_rdy"}, 32'(in_ready), 32'(0));
  endtask

  // entered and left at a negedge with the block idle
  task automatic run_job(input vec_t v);
    check("idle_busy", 32'(busy), 32'(0));
    start = 1'b1;
    len = 4'(v.n);
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    len = 4'd7;
    if (v.n != 0) check("start_to_ready", 32'(in_ready), 32'(1));
    for (int i = 0; i < v.n; i++) begin
      if (v.gap > 0) begin
        in_valid = 1'b0;
        repeat (v.gap) @(negedge clk);
      end
      in_valid = 1'b1;
      in_product = v.p[i];
      start = v.ign && i == 0;
      check("accum_ready", 32'(in_ready), 32'(1));
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b1;
    in_product = 8'($urandom);
    start = v.ign;
    check_result("done", v);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check_result("hold", v);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("consumed_valid", 32'(out_valid), 32'(0));
    check("consumed_busy", 32'(busy), 32'(0));
    if (v.ign) begin
      start = 1'b0;
      @(negedge clk);
      check("no_second_job", 32'(busy), 32'(0));
    end
  endtask

  vec_t vecs[6];
  vec_t r;

  initial begin
    vecs[0] = '{3, {96'h0, 8'hE1, 8'h10, 8'h0F}, 0, 0, 1'b0, 16'h0100, 1'b0, 10'h100, 1'b0};
    vecs[1] = '{2, {104'h0, 8'h31, 8'h09}, 3, 5, 1'b0, 16'h003A, 1'b0, 10'h03A, 1'b0};
    vecs[2] = '{0, 120'h0, 0, 1, 1'b0, 16'h0000, 1'b0, 10'h000, 1'b0};
    vecs[3] = '{5, {80'h0, {5{8'hE1}}}, 0, 2, 1'b0, 16'h0465, 1'b0, E1X5_10, 1'b1};
    vecs[4] = '{15, {15{8'hFF}}, 0, 1, 1'b0, 16'h0EF1, 1'b0, FFX15_10, 1'b1};
    vecs[5] = '{3, {96'h0, 8'hE1, 8'h10, 8'h0F}, 1, 2, 1'b1, 16'h0100, 1'b0, 10'h100, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'(0));
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_sum", 32'(out_sum), 32'(0));
    check("rst_ovf", 32'(out_ovf), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 6; k++) run_job(vecs[k]);

    // reset arriving mid-job after two of four products
    start = 1'b1;
    len = 4'd4;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_product = 8'h40;
    repeat (2) @(negedge clk);
    check("mid_partial", 32'(out_sum), 32'(16'h0080));
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'(0));
    check("mid_rst_sum", 32'(out_sum), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_valid", 32'(out_valid), 32'(0));
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    r = '{1, {112'h0, 8'h24}, 0, 0, 1'b0, 16'h0024, 1'b0, 10'h024, 1'b0};
    run_job(r);

    for (int j = 0; j < 25; j++) begin
      r.n = int'($urandom_range(0, 15));
      for (int i = 0; i < 15; i++) r.p[i] = 8'($urandom);
      r.gap = int'($urandom_range(0, 2));
      r.hold = int'($urandom_range(0, 3));
      r.ign = $urandom_range(0, 3) == 0;
      model(r);
      run_job(r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential accumulation stage directly downstream of the 4-bit array multiplier. It consumes the 8-bit product stream over a valid/ready handshake and sums a programmed number of products into a wider register, forming a dot-product or multiply-accumulate result. It presents that result on a held output handshake with a sticky overflow flag.

## Interface
- PROD_W, 8, product width; matches the multiplier output.
- ACC_W, 16, accumulator and result width; must be at least PROD_W.
- LEN_W, 4, width of the product-count field.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a job; sampled only in IDLE.
- len  in  LEN_W  number of products in the job; sampled with start.
- in_valid  in  1  in_product is valid.
- in_ready  out  1  block accepts a product this cycle.
- in_product  in  PROD_W  unsigned product from the multiplier.
- out_valid  out  1  result is valid; held until consumed.
- out_ready  in  1  downstream consumes the result.
- out_sum  out  ACC_W  accumulated result.
- out_ovf  out  1  one or more additions overflowed ACC_W during this job.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- Three states: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 and len≠0: clear the accumulator and the overflow flag, load the remaining-count register with len, then go to ACCUM.
  - start=1 and len=0: clear the accumulator and the overflow flag, then go directly to DONE.
- ACCUM:
  - in_ready=1.
  - On each handshake (in_valid & in_ready): acc ← acc + zero-extended in_product, and remaining decrements.
  - On the handshake where remaining=1, go to DONE.
- DONE:
  - out_valid=1, and out_sum/out_ovf come straight from registers.
  - On out_valid & out_ready, go to IDLE.
- Addition is unsigned, computed at ACC_W+1 bits; the carry out of the top bit sets the sticky out_ovf.
- start is ignored outside IDLE, including a start in the same cycle the block leaves DONE.
- in_valid outside ACCUM is ignored because in_ready=0. No product is dropped or double-counted.

## Timing
- Reset values:
  - State IDLE.
  - in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0.
  - Remaining count 0.
- Reset is asynchronous and may arrive mid-job. The block returns to IDLE at once and any partial sum is discarded.
- start (with len≠0) in cycle t gives in_ready=1 from cycle t+1.
- The last product accepted in cycle t gives out_valid=1 in cycle t+1, with the final sum.
- start with len=0 in cycle t gives out_valid=1, out_sum=0 in cycle t+1.
- Throughput is one product per cycle while in_valid is held high.
- With out_ready low, out_valid, out_sum and out_ovf stay stable for any number of cycles.
- Consuming the result in cycle t returns the block to IDLE at t+1, and a new start is accepted at t+1.
- Minimum job length is len+2 cycles, start to IDLE.

## Configuration
- PRODUCT_ACCUMULATOR_SATURATE_EN
  - Defined: on overflow the accumulator clamps to all-ones (2^ACC_W−1) and stays clamped for the rest of the job. out_ovf is set.
  - Undefined: the accumulator wraps modulo 2^ACC_W. out_ovf is still set.

## Structure
- Package product_accumulator_pkg holds:
  - the state enum (IDLE, ACCUM, DONE);
  - default width constants PROD_W_DEF, ACC_W_DEF, LEN_W_DEF.
- One sub-module, product_accumulator_add:
  - purely combinational ACC_W-bit adder with a carry/overflow output;
  - implements the saturate or wrap behaviour selected by the macro.
- The FSM, counter and output registers live in the top module.

## Test plan
- Basic job: len=3, products 0x0F, 0x10, 0xE1 back-to-back → out_valid 1 cycle after the third, out_sum=0x0100, out_ovf=0.
- Stalls both sides: len=2, products 0x09, 0x31, in_valid gapped 3 cycles, out_ready held low for 5 cycles → out_sum=0x003A stable throughout, then IDLE.
- Zero-length job: start with len=0 → out_valid next cycle, out_sum=0, out_ovf=0. Inputs offered with in_valid=1 are never accepted.
- Overflow with ACC_W=10: len=5, product 0xE1 each →
  - without the macro: out_sum=0x065, out_ovf=1;
  - with PRODUCT_ACCUMULATOR_SATURATE_EN: out_sum=0x3FF, out_ovf=1.
- Reset mid-job: len=4 with 2 products accepted, assert rst_n=0 → outputs return to reset values immediately. A new job with len=1, product 0x24 → out_sum=0x0024.
- Ignored start: pulse start (len=7) during ACCUM and again during DONE → the original job completes with its own count and result, and the block returns to IDLE with no second job started.
